// File: rtl/odometer_seq_ctrl_pkg.sv
// Shared definitions for the odometer measurement sequencer: state encoding,
// SEL bit positions and default widths.
package odometer_seq_ctrl_pkg;

  localparam int CNT_W_DEF = 12;

  // Bit positions inside CMD_SEL = {INV101, INV97, INV99}
  localparam int SEL_INV99  = 0;
  localparam int SEL_INV97  = 1;
  localparam int SEL_INV101 = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_LOADW,
    ST_STRESS,
    ST_MEAS,
    ST_SETTLE,
    ST_CAPTURE,
    ST_RESULT
  } state_t;

  function automatic int max_i(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/odo_count_capture.sv
// Brings the asynchronous BF_COUNT into the CLK domain and waits for two equal
// consecutive samples, giving up after CAP_TO cycles.
module odo_count_capture
  import odometer_seq_ctrl_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int CAP_TO = 8
) (
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             start,     // held high for the whole capture window
  input  logic [CNT_W-1:0] bf_count,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] count
);

  localparam int TO_W = $clog2(CAP_TO + 1);

  logic [CNT_W-1:0] sync1, sync2, prev;
  logic [TO_W-1:0]  tcnt;
  logic             match;
  logic             timeout;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      tcnt  <= '0;
    end else begin
      sync1 <= bf_count;
      sync2 <= sync1;
      prev  <= sync2;
      if (!start)
        tcnt <= '0;
      else if (tcnt != TO_W'(CAP_TO - 1))
        tcnt <= tcnt + TO_W'(1);
    end
  end

  // The first window cycle has no earlier in-window sample to compare against.
  assign match   = start && (tcnt != '0) && (sync2 == prev);
  assign timeout = start && (tcnt == TO_W'(CAP_TO - 1)) && !match;
  assign done    = match || timeout;
  assign err     = timeout;
  assign count   = sync2;

endmodule

// File: rtl/odometer_seq_ctrl.sv
// Measurement sequencer: takes one command, drives the odometer control pins
// through config/load/stress/measure/settle, captures BF_COUNT and returns it.
module odometer_seq_ctrl
  import odometer_seq_ctrl_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int STRESS_W   = 16,
  parameter int MEAS_W     = 16,
  parameter int LOAD_DLY   = 5,
  parameter int SETTLE_CYC = 4,
  parameter int CAP_TO     = 8
) (
  input  logic                CLK,
  input  logic                RESETB,
  input  logic                CMD_VALID,
  output logic                CMD_READY,
  input  logic                CMD_AC_DC,
  input  logic [2:0]          CMD_SEL,
  input  logic [STRESS_W-1:0] CMD_STRESS,
  input  logic [MEAS_W-1:0]   CMD_MEAS,
  input  logic                ABORT,
  output logic                ODO_START,
  output logic                ODO_AC_DC,
  output logic                ODO_SEL_INV99,
  output logic                ODO_SEL_INV97,
  output logic                ODO_SEL_INV101,
  output logic                ODO_LOAD,
  output logic                ODO_MEAS_TRIG,
  input  logic [CNT_W-1:0]    ODO_BF_COUNT,
  output logic                RES_VALID,
  input  logic                RES_READY,
  output logic [CNT_W-1:0]    RES_COUNT,
  output logic                RES_ERR,
  output logic                BUSY
);

  localparam int DUR_W = max_i(STRESS_W, MEAS_W);

  state_t              state, next_state;
  logic [DUR_W-1:0]    dur_cnt, dur_reload;
  logic [STRESS_W-1:0] lat_stress;
  logic [MEAS_W-1:0]   lat_meas;
  logic [2:0]          sel;
  logic                dur_done, active;
  logic                cap_done, cap_err;
  logic [CNT_W-1:0]    cap_count;

  assign dur_done = (dur_cnt == '0);
  assign active   = (state inside {ST_CONFIG, ST_LOADW, ST_STRESS, ST_MEAS,
                                   ST_SETTLE, ST_CAPTURE});

  odo_count_capture #(
    .CNT_W  (CNT_W),
    .CAP_TO (CAP_TO)
  ) u_capture (
    .CLK      (CLK),
    .RESETB   (RESETB),
    .start    (state == ST_CAPTURE),
    .bf_count (ODO_BF_COUNT),
    .done     (cap_done),
    .err      (cap_err),
    .count    (cap_count)
  );

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:    if (CMD_VALID) next_state = (CMD_SEL == 3'b000) ? ST_RESULT : ST_CONFIG;
      ST_CONFIG:  next_state = ST_LOADW;
      ST_LOADW:   if (dur_done) next_state = (lat_stress != '0) ? ST_STRESS : ST_MEAS;
      ST_STRESS:  if (dur_done) next_state = ST_MEAS;
      ST_MEAS:    if (dur_done) next_state = ST_SETTLE;
      ST_SETTLE:  if (dur_done) next_state = ST_CAPTURE;
      ST_CAPTURE: if (cap_done) next_state = ST_RESULT;
      ST_RESULT:  if (RES_READY) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
    // Abort overrides any phase end on the same edge.
    if (ABORT && active) next_state = ST_IDLE;
  end

  // Remaining-cycles value loaded when a timed state is entered.
  always_comb begin
    dur_reload = '0;
    case (next_state)
      ST_LOADW:  dur_reload = DUR_W'(LOAD_DLY - 1);
      ST_STRESS: dur_reload = DUR_W'(lat_stress) - DUR_W'(1);
      ST_MEAS:   dur_reload = (lat_meas == '0) ? '0 : DUR_W'(lat_meas) - DUR_W'(1);
      ST_SETTLE: dur_reload = DUR_W'(SETTLE_CYC - 1);
      default:   dur_reload = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state      <= ST_IDLE;
      dur_cnt    <= '0;
      lat_stress <= '0;
      lat_meas   <= '0;
    end else begin
      state <= next_state;
      if (next_state != state)
        dur_cnt <= dur_reload;
      else if (!dur_done)
        dur_cnt <= dur_cnt - DUR_W'(1);
      if (state == ST_IDLE && CMD_VALID) begin
        lat_stress <= CMD_STRESS;
        lat_meas   <= CMD_MEAS;
      end
    end
  end

  // Outputs are flops decoded from next_state so they line up with the state register.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      ODO_START     <= 1'b0;
      ODO_AC_DC     <= 1'b0;
      sel           <= 3'b000;
      ODO_LOAD      <= 1'b0;
      ODO_MEAS_TRIG <= 1'b0;
      RES_VALID     <= 1'b0;
      RES_COUNT     <= '0;
      RES_ERR       <= 1'b0;
      CMD_READY     <= 1'b1;
      BUSY          <= 1'b0;
    end else begin
      CMD_READY     <= (next_state == ST_IDLE);
      BUSY          <= (next_state != ST_IDLE);
      ODO_MEAS_TRIG <= (next_state == ST_MEAS);
      RES_VALID     <= (next_state == ST_RESULT);
      if (next_state == ST_IDLE) begin
        ODO_START <= 1'b0;
        ODO_AC_DC <= 1'b0;
        sel       <= 3'b000;
        ODO_LOAD  <= 1'b0;
      end else begin
        if (state == ST_IDLE && next_state == ST_CONFIG) begin
          ODO_START <= 1'b1;
          ODO_AC_DC <= CMD_AC_DC;
          sel       <= CMD_SEL;
        end
        if (next_state == ST_LOADW) ODO_LOAD <= 1'b1;
      end
      if (state == ST_IDLE && next_state == ST_RESULT) begin
        RES_COUNT <= '0;
        RES_ERR   <= 1'b1;
      end else if (state == ST_CAPTURE && next_state == ST_RESULT) begin
        RES_COUNT <= cap_count;
        RES_ERR   <= cap_err;
      end
    end
  end

  assign ODO_SEL_INV99  = sel[SEL_INV99];
  assign ODO_SEL_INV97  = sel[SEL_INV97];
  assign ODO_SEL_INV101 = sel[SEL_INV101];

endmodule
